// File: rtl/cfg_pkg.sv
// Shared constants for the fabric configuration loader: default widths and FSM state encodings.
// Optional readback datapath in the loader is enabled with CONFIG_READBACK_EN.
package cfg_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int LEN_W_DEF  = 20;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_SET   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/cfg_serializer.sv
// Holding register and bit pointer that turn one configuration word into an LSB-first bit stream.
module cfg_serializer
    import cfg_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] din,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] hold;
    logic [IDX_W-1:0]  bit_idx;

    // NOTE: hold is pure data and every use of it is gated by cfg_cen, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) hold <= din;
    end

    always_ff @(posedge clk) begin
        if (rst)          bit_idx <= '0;
        else if (load)    bit_idx <= '0;
        else if (advance) bit_idx <= bit_idx + 1'b1;
    end

    assign bit_out  = hold[bit_idx];
    assign last_bit = (bit_idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration words LSB first into the fabric shift chain, then pulses cset.
// Define CONFIG_READBACK_EN to add the shift_out capture path (cfg_ret, rb_word, rb_valid).
module fpga_config_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  num_bits,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              cfg_cen,
    output logic              cfg_shift,
    output logic              cfg_set,
    output logic              busy,
    output logic              done
`ifdef CONFIG_READBACK_EN
    ,
    input  logic              cfg_ret,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid
`endif
);

    logic [2:0]       state;
    logic [LEN_W-1:0] bits_left;
    logic             in_shift;
    logic             last_bit;
    logic             ser_bit;
    logic             accept;

    assign in_shift  = (state == ST_SHIFT);
    // A word may also be taken on the last bit of the previous one so cen has no gap.
    assign din_ready = (state == ST_LOAD) ||
                       (in_shift && last_bit && (bits_left > LEN_W'(1)));
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bits_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bits_left <= num_bits;
                        state     <= (num_bits == '0) ? ST_SET : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (din_valid) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bits_left <= bits_left - 1'b1;
                    if (bits_left == LEN_W'(1)) state <= ST_SET;
                    else if (last_bit)          state <= din_valid ? ST_SHIFT : ST_LOAD;
                end
                ST_SET:  state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    cfg_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (in_shift),
        .din      (din),
        .bit_out  (ser_bit),
        .last_bit (last_bit)
    );

    assign cfg_cen   = in_shift;
    assign cfg_shift = in_shift & ser_bit;
    assign cfg_set   = (state == ST_SET);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef CONFIG_READBACK_EN
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0]  rb_cnt;
    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_next;

    // Starting each word from zero leaves the high bits of a final partial word cleared.
    always_comb begin
        rb_next         = (rb_cnt == '0) ? '0 : rb_acc;
        rb_next[rb_cnt] = cfg_ret;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_cnt   <= '0;
            rb_acc   <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (cfg_cen) begin
                rb_acc <= rb_next;
                if ((rb_cnt == IDX_W'(WORD_W - 1)) || (bits_left == LEN_W'(1))) begin
                    rb_word  <= rb_next;
                    rb_valid <= 1'b1;
                    rb_cnt   <= '0;
                end else begin
                    rb_cnt <= rb_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
Transmitter side of the fabric configuration shift chain. It accepts configuration words over a valid/ready stream and serialises them, LSB first, onto the fabric's shift_in input, with cen high on every cycle that carries a real bit. After the programmed bit count has been shifted it pulses cset for one cycle. It sits between the Caravel-side bus glue and the fpga top-level configuration pins.

Parameters:
WORD_W, 32, width of one input configuration word.
LEN_W, 20, width of the bit-count field; the maximum stream length is 2^LEN_W-1 bits.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  begin a load; sampled only in IDLE
num_bits  input  LEN_W  total chain bits to shift; sampled on the cycle start is accepted
din  input  WORD_W  configuration word
din_valid  input  1  din is valid
din_ready  output  1  loader accepts din this cycle
cfg_cen  output  1  drives fabric cen; high on each real shift cycle
cfg_shift  output  1  drives fabric shift_in
cfg_set  output  1  drives fabric cset; one-cycle latch pulse
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset: clk and rst are fixed as one clock with synchronous, active-high reset. On reset the state goes to IDLE and all outputs are 0: din_ready, cfg_cen, cfg_shift, cfg_set, busy, done. Reset mid-load aborts immediately; no cset is issued.
- States:
  - IDLE -> LOAD on start when num_bits != 0.
  - IDLE -> SET on start when num_bits == 0.
  - LOAD: din_ready=1. The handshake (din_valid && din_ready) loads the holding register and goes to SHIFT.
  - SHIFT: cfg_cen=1 and cfg_shift = hold[bit_idx], with bit_idx running 0..WORD_W-1. Each cycle decrements bits_left.
  - bits_left reaching 0 -> SET, even in mid-word. The unused upper bits of that word are discarded.
  - bit_idx == WORD_W-1 with bits_left > 1 -> LOAD, unless a word is accepted that same cycle.
  - SET: cfg_set=1 and cfg_cen=0 for exactly one cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Back-to-back: din_ready is also high in SHIFT on the last bit of a word when bits_left > 1. A handshake there makes the next word's bit 0 appear on the following cycle, with no cen gap.
- Latency: for a word accepted at cycle N, its bits appear on cfg_shift with cfg_cen=1 at cycles N+1 .. N+WORD_W.
- Stall: in LOAD with no valid, cfg_cen=0 and cfg_shift=0; the fabric holds its state.
- cfg_shift is 0 whenever cfg_cen=0.
- start while busy is ignored. num_bits is captured only at the accepted start.
- din_ready is 0 in IDLE, SET and DONE. Valid data offered there is not consumed.
- All outputs are registered-state decodes with no combinational path from din_valid to cfg_*. din_ready may depend combinationally on state only.

Optional Feature:
CONFIG_READBACK_EN
- Defined: adds ports cfg_ret (input 1, from fabric shift_out), rb_word (output WORD_W) and rb_valid (output 1).
  - On every cycle with cfg_cen=1, cfg_ret is shifted into a WORD_W register, LSB first.
  - rb_valid pulses for one cycle when WORD_W bits have been collected, or when the final partial word completes (zero-filled high bits).
  - rb_word and rb_valid reset to 0.
- Undefined: these ports and the logic are absent; core behaviour is identical.

Decomposition:
- Shared package cfg_pkg holds the state enum (IDLE, LOAD, SHIFT, SET, DONE) and default WORD_W/LEN_W constants.
- One natural sub-module, cfg_serializer: holding register, bit_idx counter and the cfg_shift mux.
- The FSM and bits_left counter stay in the top-level module.

Test Plan:
- WORD_W=32, num_bits=32, din=32'hA5A5_0001 offered immediately -> cfg_cen high for 32 consecutive cycles with cfg_shift sequence 1,0,0,...,1,0,1,0,0,1,0,1. Then cfg_set one cycle, then done one cycle.
- num_bits=40, two words with din_valid always high -> 40 contiguous cen cycles. Bits 8..31 of the second word are never shifted. cset follows the 40th bit.
- num_bits=64, din_valid dropped for 3 cycles between words -> cen low for exactly those 3 cycles. The bit stream is otherwise unchanged, for a total of 64 cen cycles.
- num_bits=0 -> no cen cycles; cset at start+1, done at start+2.
- rst asserted midway through a 96-bit load -> all outputs 0 next cycle, no cset. A subsequent start with num_bits=32 completes normally.
- CONFIG_READBACK_EN with cfg_ret looped to cfg_shift -> rb_word equals each shifted word, and rb_valid pulses once per word.
